// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (640x480@60 by default) with sync, visible-area decode and a start-of-vblank pulse
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk_in,
   input  logic       i_rst,
   output logic       o_pix_stb,
   output logic       o_hs,
   output logic       o_vs,
   output logic       o_active,
   output logic [9:0] o_x,
   output logic [8:0] o_y,
   output logic       o_animate,
   output logic [7:0] o_frame_cnt
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   logic [3:0] div_q, div_d;
   logic [9:0] h_q, h_d, v_q, v_d;
   logic [7:0] frame_q, frame_d;
   logic       anim_q, anim_d;
   logic       pix_stb, h_wrap, v_wrap;
   assign pix_stb = div_q == 4'(CLK_DIV - 1);
   assign h_wrap  = h_q == 10'(H_TOTAL - 1);
   assign v_wrap  = v_q == 10'(V_TOTAL - 1);
   // Free-running divider and raster counters; animate fires on the edge entering (0, V_ACTIVE)
   always_comb begin
      div_d   = pix_stb ? 4'd0 : div_q + 4'd1;
      h_d     = !pix_stb ? h_q : h_wrap ? 10'd0 : h_q + 10'd1;
      v_d     = !(pix_stb && h_wrap) ? v_q : v_wrap ? 10'd0 : v_q + 10'd1;
      frame_d = (pix_stb && h_wrap && v_wrap) ? frame_q + 8'd1 : frame_q;
      anim_d  = pix_stb && h_wrap && v_q == 10'(V_ACTIVE - 1);
   end
   // State registers; reset returns the raster to the origin immediately
   always_ff @(posedge clk_in or posedge i_rst) begin
      if (i_rst) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
         anim_q  <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= frame_d;
         anim_q  <= anim_d;
      end
   end
   // Output decode straight from the registered counters, no extra pipeline stage
   always_comb begin
      o_active = h_q < 10'(H_ACTIVE) && v_q < 10'(V_ACTIVE);
      o_hs     = !(h_q >= 10'(H_ACTIVE + H_FP) && h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
      o_vs     = !(v_q >= 10'(V_ACTIVE + V_FP) && v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
      o_x      = o_active ? h_q : 10'd0;
      o_y      = o_active ? v_q[8:0] : 9'd0;
   end
   assign o_pix_stb   = pix_stb;
   assign o_animate   = anim_q;
   assign o_frame_cnt = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks raster timing against an elapsed-time arithmetic model
module tb_vga_timing_gen;
   localparam int SHA = 8, SHFP = 2, SHS = 3, SHBP = 2;
   localparam int SVA = 4, SVFP = 1, SVS = 2, SVBP = 1;
   localparam int SFRAME = (SHA + SHFP + SHS + SHBP) * (SVA + SVFP + SVS + SVBP);
   logic clk = 1'b0, rst0 = 1'b1, rst_s = 1'b1;
   int checks = 0, failures = 0, t0 = 0, ts = 0;
   wire [31:0] ob0, ob1, ob2, ob3;
   logic [31:0] e0, e1, e2, e3;
   always #5 clk = ~clk;
   always @(posedge clk or posedge rst0) begin
      if (rst0) t0 <= 0;
      else t0 <= t0 + 1;
   end
   always @(posedge clk or posedge rst_s) begin
      if (rst_s) ts <= 0;
      else ts <= ts + 1;
   end
   vga_timing_gen #(.CLK_DIV(2)) d0 (.clk_in(clk), .i_rst(rst0), .o_pix_stb(ob0[31]), .o_hs(ob0[30]),
      .o_vs(ob0[29]), .o_active(ob0[28]), .o_x(ob0[27:18]), .o_y(ob0[17:9]), .o_animate(ob0[8]), .o_frame_cnt(ob0[7:0]));
   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP), .V_ACTIVE(SVA), .V_FP(SVFP),
      .V_SYNC(SVS), .V_BP(SVBP)) d1 (.clk_in(clk), .i_rst(rst_s), .o_pix_stb(ob1[31]), .o_hs(ob1[30]), .o_vs(ob1[29]),
      .o_active(ob1[28]), .o_x(ob1[27:18]), .o_y(ob1[17:9]), .o_animate(ob1[8]), .o_frame_cnt(ob1[7:0]));
   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP), .V_ACTIVE(SVA), .V_FP(SVFP),
      .V_SYNC(SVS), .V_BP(SVBP)) d2 (.clk_in(clk), .i_rst(rst_s), .o_pix_stb(ob2[31]), .o_hs(ob2[30]), .o_vs(ob2[29]),
      .o_active(ob2[28]), .o_x(ob2[27:18]), .o_y(ob2[17:9]), .o_animate(ob2[8]), .o_frame_cnt(ob2[7:0]));
   vga_timing_gen #(.CLK_DIV(1)) d3 (.clk_in(clk), .i_rst(rst0), .o_pix_stb(ob3[31]), .o_hs(ob3[30]),
      .o_vs(ob3[29]), .o_active(ob3[28]), .o_x(ob3[27:18]), .o_y(ob3[17:9]), .o_animate(ob3[8]), .o_frame_cnt(ob3[7:0]));

   // Expected outputs after t clock edges since reset release: pixel index p = t / d
   function automatic logic [31:0] model(int t, int d, int ha, int hfp, int hsy, int hbp, int va, int vfp, int vsy, int vbp);
      int ht, vt, p, h, v, f;
      logic act;
      ht  = ha + hfp + hsy + hbp;
      vt  = va + vfp + vsy + vbp;
      p   = t / d;
      h   = p % ht;
      v   = (p / ht) % vt;
      f   = (p / (ht * vt)) % 256;
      act = (h < ha) && (v < va);
      return {t % d == d - 1, !(h >= ha + hfp && h < ha + hfp + hsy), !(v >= va + vfp && v < va + vfp + vsy), act,
              act ? 10'(h) : 10'd0, act ? 9'(v) : 9'd0, t > 0 && t % d == 0 && h == 0 && v == va, 8'(f)};
   endfunction
   function automatic logic [31:0] mbig(int t, int d);
      return model(t, d, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction
   function automatic logic [31:0] msmall(int t, int d);
      return model(t, d, SHA, SHFP, SHS, SHBP, SVA, SVFP, SVS, SVBP);
   endfunction

   task automatic test_reset;
      rst0 = 1'b1;
      rst_s = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (ob0 !== 32'h7000_0000) begin failures++; $display("FAIL reset_d0 got=%h exp=%h", ob0, 32'h7000_0000); end
      if (ob1 !== 32'h7000_0000) begin failures++; $display("FAIL reset_d1 got=%h exp=%h", ob1, 32'h7000_0000); end
      if (ob2 !== 32'hF000_0000) begin failures++; $display("FAIL reset_d2 got=%h exp=%h", ob2, 32'hF000_0000); end
      if (ob3 !== 32'hF000_0000) begin failures++; $display("FAIL reset_d3 got=%h exp=%h", ob3, 32'hF000_0000); end
      rst0 = 1'b0;
      rst_s = 1'b0;
      #1;
      checks++;
      if (ob0[31] !== 1'b0) begin failures++; $display("FAIL first_cycle_stb got=%b exp=0", ob0[31]); end
      @(negedge clk);
      checks++;
      if (ob0[31] !== 1'b1 || ob0[27:18] !== 10'd0) begin
         failures++; $display("FAIL second_cycle stb=%b x=%0d exp stb=1 x=0", ob0[31], ob0[27:18]);
      end
      @(negedge clk);
      checks++;
      if (ob0[31] !== 1'b0 || ob0[27:18] !== 10'd1) begin
         failures++; $display("FAIL third_cycle stb=%b x=%0d exp stb=0 x=1", ob0[31], ob0[27:18]);
      end
   endtask

   task automatic test_line;
      int act0 = 0, hs0 = 0, hf0 = -1, act3 = 0, hs3 = 0, hf3 = -1;
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      for (int k = 0; k <= 1700; k++) begin
         if (k > 0) @(negedge clk);
         e0 = mbig(t0, 2);
         e3 = mbig(t0, 1);
         checks += 2;
         if (ob0 !== e0) begin failures++; $display("FAIL line_d0 t=%0d got=%h exp=%h", t0, ob0, e0); end
         if (ob3 !== e3) begin failures++; $display("FAIL line_d3 t=%0d got=%h exp=%h", t0, ob3, e3); end
         if (t0 < 1600) begin act0 += int'(ob0[28]); hs0 += int'(!ob0[30]); end
         if (t0 < 800) begin act3 += int'(ob3[28]); hs3 += int'(!ob3[30]); end
         if (hf0 < 0 && ob0[30] === 1'b0) hf0 = t0;
         if (hf3 < 0 && ob3[30] === 1'b0) hf3 = t0;
         if (t0 == 1600) begin
            checks++;
            if (ob0[28] !== 1'b1 || ob0[27:18] !== 10'd0 || ob0[17:9] !== 9'd1) begin
               failures++; $display("FAIL line_period_d0 act=%b x=%0d y=%0d exp 1/0/1", ob0[28], ob0[27:18], ob0[17:9]);
            end
         end
         if (t0 == 800) begin
            checks++;
            if (ob3[28] !== 1'b1 || ob3[27:18] !== 10'd0 || ob3[17:9] !== 9'd1) begin
               failures++; $display("FAIL line_period_d3 act=%b x=%0d y=%0d exp 1/0/1", ob3[28], ob3[27:18], ob3[17:9]);
            end
         end
      end
      checks += 6;
      if (act0 != 1280) begin failures++; $display("FAIL active_len_d0 got=%0d exp=1280", act0); end
      if (hs0 != 192) begin failures++; $display("FAIL hs_len_d0 got=%0d exp=192", hs0); end
      if (hf0 != 1312) begin failures++; $display("FAIL hs_start_d0 got=%0d exp=1312", hf0); end
      if (act3 != 640) begin failures++; $display("FAIL active_len_d3 got=%0d exp=640", act3); end
      if (hs3 != 96) begin failures++; $display("FAIL hs_len_d3 got=%0d exp=96", hs3); end
      if (hf3 != 656) begin failures++; $display("FAIL hs_start_d3 got=%0d exp=656", hf3); end
   endtask

   task automatic test_frames;
      int n = 257 * 2 * SFRAME, an1 = 0, an2 = 0, ch1 = 0, ch2 = 0;
      logic [7:0] p1 = 8'd0, p2 = 8'd0;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      #1;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) @(negedge clk);
         e1 = msmall(ts, 2);
         e2 = msmall(ts, 1);
         checks += 2;
         if (ob1 !== e1) begin failures++; $display("FAIL frame_d1 t=%0d got=%h exp=%h", ts, ob1, e1); end
         if (ob2 !== e2) begin failures++; $display("FAIL frame_d2 t=%0d got=%h exp=%h", ts, ob2, e2); end
         an1 += int'(ob1[8]);
         an2 += int'(ob2[8]);
         if (ob1[7:0] !== p1) begin
            ch1++; checks++;
            if (ob1[7:0] !== p1 + 8'd1) begin failures++; $display("FAIL frame_seq_d1 got=%0d exp=%0d", ob1[7:0], p1 + 8'd1); end
            p1 = ob1[7:0];
         end
         if (ob2[7:0] !== p2) begin ch2++; p2 = ob2[7:0]; end
      end
      checks += 6;
      if (an1 != 257) begin failures++; $display("FAIL animate_count_d1 got=%0d exp=257", an1); end
      if (an2 != 514) begin failures++; $display("FAIL animate_count_d2 got=%0d exp=514", an2); end
      if (ch1 != 257) begin failures++; $display("FAIL frame_steps_d1 got=%0d exp=257", ch1); end
      if (ch2 != 514) begin failures++; $display("FAIL frame_steps_d2 got=%0d exp=514", ch2); end
      if (ob1[7:0] !== 8'd1) begin failures++; $display("FAIL frame_final_d1 got=%0d exp=1", ob1[7:0]); end
      if (ob2[7:0] !== 8'd2) begin failures++; $display("FAIL frame_final_d2 got=%0d exp=2", ob2[7:0]); end
   endtask

   task automatic test_async_reset;
      int n, hold;
      rst_s = 1'b1;
      @(negedge clk);
      rst_s = 1'b0;
      for (int i = 0; i < 9; i++) begin
         n = (i == 0) ? 74 : int'($urandom_range(20, 400));
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e1 = msmall(ts, 2);
            e2 = msmall(ts, 1);
            checks += 2;
            if (ob1 !== e1) begin failures++; $display("FAIL pre_rst_d1 t=%0d got=%h exp=%h", ts, ob1, e1); end
            if (ob2 !== e2) begin failures++; $display("FAIL pre_rst_d2 t=%0d got=%h exp=%h", ts, ob2, e2); end
         end
         #($urandom_range(1, 3));
         rst_s = 1'b1;
         #1;
         checks += 2;
         if (ob1 !== 32'h7000_0000) begin failures++; $display("FAIL async_rst_d1 got=%h exp=%h", ob1, 32'h7000_0000); end
         if (ob2 !== 32'hF000_0000) begin failures++; $display("FAIL async_rst_d2 got=%h exp=%h", ob2, 32'hF000_0000); end
         hold = int'($urandom_range(0, 3));
         repeat (hold) @(negedge clk);
         #1;
         rst_s = 1'b0;
      end
   endtask

   task automatic test_clkdiv1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         e2 = msmall(ts, 1);
         checks += 2;
         if (ob2[31] !== 1'b1) begin failures++; $display("FAIL div1_stb t=%0d got=%b exp=1", ts, ob2[31]); end
         if (ob2 !== e2) begin failures++; $display("FAIL div1_d2 t=%0d got=%h exp=%h", ts, ob2, e2); end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frames();
      test_async_reset();
      test_clkdiv1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the board clock. Drives the shared o_active/o_x/o_y raster bus consumed by the paddle and ball renderers, and the sync pins. Also provides a once-per-frame pulse marking the start of vertical blanking, so game logic and Nios custom instructions can update object coordinates while nothing is being drawn.

Parameters:
CLK_DIV, 2, clk_in cycles per pixel (50 MHz / 2 = 25 MHz pixel rate); legal values 1..15
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk_in  input  1  board clock; all logic is on its rising edge
i_rst  input  1  asynchronous, active-high reset
o_pix_stb  output  1  one-clk_in pulse on each pixel tick
o_hs  output  1  horizontal sync, active low
o_vs  output  1  vertical sync, active low
o_active  output  1  high while (h_cnt, v_cnt) is inside the visible area
o_x  output  10  visible x (0..639); 0 outside the active area
o_y  output  9  visible y (0..479); 0 outside the active area
o_animate  output  1  one-clk_in pulse when v_cnt enters V_ACTIVE at h_cnt 0
o_frame_cnt  output  8  completed-frame counter; wraps 255 to 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525. Internal h_cnt and v_cnt are both 10 bits.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_stb = (div_cnt == CLK_DIV-1). o_pix_stb = pix_stb, taken combinationally from the registered div_cnt.
- Counters advance only on clock edges where pix_stb = 1:
  - h_cnt = H_TOTAL-1 wraps to 0. Otherwise h_cnt + 1.
  - On the h_cnt wrap, v_cnt increments. v_cnt = V_TOTAL-1 wraps to 0.
  - On the v_cnt wrap, o_frame_cnt increments, modulo 256.
- Decode: every output is a combinational function of the registered counters, with no extra pipeline stage. Outputs therefore change in the clk_in cycle immediately after the advancing edge.
  - o_hs = 0 when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751; else 1.
  - o_vs = 0 when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491; else 1.
  - o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - o_x = o_active ? h_cnt[9:0] : 0.
  - o_y = o_active ? v_cnt[8:0] : 0.
- o_animate: a registered flag, set for exactly one clk_in cycle on the edge where the counters become (h=0, v=V_ACTIVE). It is asserted for the whole first clk_in cycle of vertical blanking and cleared on the next edge, even when CLK_DIV > 1.
- Reset (asynchronous, takes effect immediately with no clock edge):
  - div_cnt = 0, h_cnt = 0, v_cnt = 0, o_frame_cnt = 0, o_animate = 0.
  - Decoded outputs under reset: o_active = 1, o_x = 0, o_y = 0, o_hs = 1, o_vs = 1, o_pix_stb = (CLK_DIV==1).
  - Reset mid-line or mid-frame discards the partial frame. After release the raster restarts at the origin with a full first pixel period.
- Simultaneous wraps: when h and v both wrap on the same strobe, the frame counter increments on that same edge. The next state is (0,0).
- Nothing stalls the counters: there is no enable input, and counting is free-running.

Test Plan:
1. Assert i_rst with clk_in running, deassert, CLK_DIV=2 -> o_x=0, o_y=0, o_active=1, o_hs=1, o_vs=1 under reset. First o_pix_stb appears on the 2nd clk_in cycle after release, and o_x=1 appears in the following cycle.
2. Run one line -> o_active high for 1280 clk_in cycles. o_hs low for exactly 192 clk_in cycles, starting 1312 cycles after the line start (h_cnt=656). Line period is 1600 clk_in cycles.
3. Run one frame -> period is 840000 clk_in cycles. o_vs low for 3200 cycles covering v_cnt 490..491. o_y never exceeds 479, and o_x/o_y read 0 whenever o_active=0.
4. Run 257 frames -> exactly one o_animate pulse per frame, 1 clk_in wide, coincident with the first cycle of v_cnt=480 and h_cnt=0. o_frame_cnt sequence is 1..255,0,1.
5. Pulse i_rst asynchronously (between clock edges) at h_cnt=400, v_cnt=200 -> counters and outputs reach their reset values before the next clk_in edge. No o_animate is produced. Timing restarts cleanly from (0,0).
6. CLK_DIV=1 -> o_pix_stb stuck high. Line period is 800 cycles and frame period is 420000 cycles; o_animate is still 1 cycle wide.
